fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised multi-lane instruction queue between fetch/predecode and decode.
//  Accepts up to PUSH_W {pc_next,pc,inst} entries per cycle and compacts them, so invalid lanes never occupy slots.
//  Presents the POP_W oldest entries in order to the decoders. Decode can consume 0..POP_W of them per cycle.
//  Replaces the fixed 2x4 interleaved buffer: any power-of-two depth, no wasted slot, no per-bank select flops.
// PARAMETERS
//  DEPTH    8    entries; power of two, >= 2*max(PUSH_W,POP_W)
//  PUSH_W   2    input lanes per cycle (1..4)
//  POP_W    2    output lanes per cycle (1..4)
//  ENTRY_W  96   payload bits: [31:0] inst, [63:32] pc, [95:64] pc_next
//  PAD      {32'd4,32'd0,`INST_NOP}   driven on output lanes that hold no entry
// PORTS
//  clk        in   1               clock, rising edge
//  rstn       in   1               asynchronous active-low reset
//  flush      in   1               synchronous clear (branch mispredict / exception)
//  in_valid   in   PUSH_W          per-lane valid; any bit pattern is legal
//  in_data    in   PUSH_W*ENTRY_W  lane i at [i*ENTRY_W +: ENTRY_W]; lane 0 is oldest
//  in_ready   out  1               queue can take a full PUSH_W group this cycle
//  out_valid  out  POP_W           thermometer: bit i set iff >= i+1 entries held
//  out_data   out  POP_W*ENTRY_W   lane 0 = oldest entry; PAD where out_valid[i]=0
//  pop_cnt    in   $clog2(POP_W+1) entries consumed this cycle
//  count      out  $clog2(DEPTH+1) current occupancy
//  full       out  1               ~in_ready (stall to fetch)
// BEHAVIOUR
//  - Reset (rstn=0, async): head=0, tail=0, count=0, so out_valid=0, in_ready=1, full=0, out_data=PAD. Storage is not reset.
//  - in_ready = (DEPTH - count) >= PUSH_W. It uses registered count only. A same-cycle pop gives no credit, so there is no comb path from pop_cnt.
//  - Push fires when in_ready & |in_valid.
//    - Valid lanes are compacted in lane order and written to tail, tail+1, ...
//    - n_push = popcount(in_valid).
//    - If in_valid != 0 while in_ready=0, the group is dropped. Fetch holds the group while full=1.
//  - Pop: n_pop = min(pop_cnt, count).
//    - pop_cnt > count is a protocol violation: flag it with an assertion, and the hardware clamps.
//    - head advances by n_pop.
//  - count_next = count + n_push - n_pop. Push and pop in the same cycle are legal at any occupancy.
//  - Latency: an entry pushed in cycle t is visible on out_* in cycle t+1. There is no bypass.
//  - out_data is combinational from head and count. Lane i reads mem[head+i] mod DEPTH.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally. A read window that straddles the wrap point must return the correct order.
//  - Flush (sync): head=tail=count=0 next cycle. Flush wins over a simultaneous push and pop; both are discarded.
//  - Reset asserted mid-operation clears all state immediately. The first push after deassertion lands in slot 0.
//  - No state machine. State is head, tail and count only. out_valid is derived, never stored.
// STRUCTURE
//  - `uop.vh` gains FQ_INST/FQ_PC/FQ_PCNEXT field ranges and FQ_PAD, shared with the decoder that splits entries.
//  - `uop.vh` keeps `INST_NOP.
//  - Sub-module fq_compact (combinational):
//    - Inputs in_valid and in_data.
//    - Outputs packed lanes plus n_push via a prefix-sum of in_valid.
//    - Reused by any future multi-lane enqueue.
//  - Top level holds the memory array, pointers, count, and the output read mux.
// TESTING
//  1. Reset, then push in_valid=2'b11 with pcs 0x1c000000/0x1c000004 and pop_cnt=0.
//     -> Next cycle count=2, out_valid=2'b11, lane0 pc=0x1c000000.
//  2. in_valid=2'b10 (lane0 killed by predictor) with pc1=0x1c000014.
//     -> One entry stored, at lane0 of the output. count increments by 1.
//  3. Fill to DEPTH-1=7 entries.
//     -> in_ready=0, full=1. A push of 2'b11 with pop_cnt=2 in that cycle leaves count=5 and the push is dropped.
//  4. Wrap: push and pop 2 per cycle for 20 cycles from head=6.
//     -> Output order is strictly increasing pc; count stays constant; no PAD on valid lanes.
//  5. flush=1 together with a push of 2'b11 and pop_cnt=1 at count=4.
//     -> Next cycle count=0, out_valid=0, out_data=PAD on both lanes.
//  6. Async rstn pulse mid-cycle at count=3.
//     -> out_valid drops to 0 before the next edge. After release, a push lands at head.
//     Random regression against a queue scoreboard, with PUSH_W/POP_W in {1,2,4} and DEPTH in {4,8,16}.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the multi-lane fetch queue and the decoder that splits its entries.
// Entry layout: [31:0] inst, [63:32] pc, [95:64] pc_next.
// PAD is what an output lane carries when it holds no entry: a NOP at pc 0 with pc_next 4.
package fetch_queue_pkg;

  localparam int FQ_ENTRY_W    = 96;
  localparam int FQ_FIELD_W    = 32;
  localparam int FQ_INST_LSB   = 0;
  localparam int FQ_PC_LSB     = 32;
  localparam int FQ_PCNEXT_LSB = 64;

  // andi r0, r0, 0
  localparam logic [31:0] INST_NOP = 32'h0340_0000;

  typedef struct packed {
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  localparam fq_entry_t FQ_PAD = '{pc_next: 32'd4, pc: 32'd0, inst: INST_NOP};

endpackage

// File: rtl/fq_compact.sv
// Packs the valid lanes of a multi-lane group into the low lanes, in lane order.
// Latency: combinational. Backpressure: none; the caller decides whether the group is taken.
// Ports: in_valid/in_data (W lanes, lane 0 oldest) -> lane_data (packed lanes), n_push (popcount).
module fq_compact #(
  parameter int W       = 2,
  parameter int ENTRY_W = 96,
  parameter int N_W     = $clog2(W + 1)
) (
  input  logic [W-1:0]         in_valid,
  input  logic [W*ENTRY_W-1:0] in_data,
  output logic [W*ENTRY_W-1:0] lane_data,
  output logic [N_W-1:0]       n_push
);

  // pos is the running prefix sum of in_valid: the slot the next valid lane goes to.
  always_comb begin
    logic [N_W-1:0] pos;
    pos       = '0;
    lane_data = '0;
    for (int i = 0; i < W; i++) begin
      if (in_valid[i]) begin
        lane_data[pos*ENTRY_W +: ENTRY_W] = in_data[i*ENTRY_W +: ENTRY_W];
        pos = pos + N_W'(1);
      end
    end
    n_push = pos;
  end

endmodule

// File: rtl/fetch_queue.sv
// Multi-lane instruction queue between fetch/predecode and decode; compacts pushes, pops 0..POP_W oldest.
// Latency: one cycle from push to visibility on out_*; no bypass.
// Backpressure: in_ready/full from registered count only; a group offered while full is dropped.
// Ports: clk, rstn (async low), flush; in_valid/in_data/in_ready push side;
//        out_valid/out_data/pop_cnt pop side; count occupancy; full = ~in_ready.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                 DEPTH   = 8,
  parameter int                 PUSH_W  = 2,
  parameter int                 POP_W   = 2,
  parameter int                 ENTRY_W = FQ_ENTRY_W,
  parameter logic [ENTRY_W-1:0] PAD     = FQ_PAD
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic [PUSH_W-1:0]            in_valid,
  input  logic [PUSH_W*ENTRY_W-1:0]    in_data,
  output logic                         in_ready,
  output logic [POP_W-1:0]             out_valid,
  output logic [POP_W*ENTRY_W-1:0]     out_data,
  input  logic [$clog2(POP_W+1)-1:0]   pop_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NP_W  = $clog2(PUSH_W + 1);

  logic [PTR_W-1:0]          head_q, head_d;
  logic [PTR_W-1:0]          tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [ENTRY_W-1:0]        mem_q [DEPTH];

  logic [PUSH_W*ENTRY_W-1:0] cmp_data;
  logic [NP_W-1:0]           cmp_n;
  logic                      push_fire;
  logic [CNT_W-1:0]          n_push;
  logic [CNT_W-1:0]          n_pop;

  fq_compact #(
    .W       (PUSH_W),
    .ENTRY_W (ENTRY_W),
    .N_W     (NP_W)
  ) u_compact (
    .in_valid  (in_valid),
    .in_data   (in_data),
    .lane_data (cmp_data),
    .n_push    (cmp_n)
  );

  // Credit is based on registered occupancy only, so a same-cycle pop never
  // opens room for a push and pop_cnt has no path to in_ready.
  assign in_ready  = (CNT_W'(DEPTH) - count_q) >= CNT_W'(PUSH_W);
  assign full      = ~in_ready;
  assign count     = count_q;

  assign push_fire = in_ready & (|in_valid) & ~flush;
  assign n_push    = push_fire ? CNT_W'(cmp_n) : '0;
  // Over-pop is a protocol error; clamp so the pointers stay coherent anyway.
  assign n_pop     = (CNT_W'(pop_cnt) > count_q) ? count_q : CNT_W'(pop_cnt);

  always_comb begin
    head_d  = head_q + PTR_W'(n_pop);
    tail_d  = tail_q + PTR_W'(n_push);
    count_d = count_q + n_push - n_pop;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int j = 0; j < PUSH_W; j++) begin
      if (CNT_W'(j) < n_push) begin
        mem_q[tail_q + PTR_W'(j)] <= cmp_data[j*ENTRY_W +: ENTRY_W];
      end
    end
  end

  // Pointer arithmetic wraps modulo DEPTH, so a window straddling the end of
  // the array still comes out oldest-first.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < POP_W; i++) begin
      out_valid[i] = count_q > CNT_W'(i);
      out_data[i*ENTRY_W +: ENTRY_W] = out_valid[i] ? mem_q[head_q + PTR_W'(i)] : PAD;
    end
  end

  a_pop_le_count: assert property (@(posedge clk) disable iff (!rstn) CNT_W'(pop_cnt) <= count_q);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH 8, 2 push lanes, 2 pop lanes).
// Inputs are driven 1 ns after the rising edge; outputs are checked there too.
// A small pc queue tracks expected order through the wrap-around phase.
module tb_fetch_queue;

  localparam int DEPTH  = 8;
  localparam int PUSH_W = 2;
  localparam int POP_W  = 2;
  localparam int EW     = 96;

  localparam logic [95:0] PADV = {32'd4, 32'd0, 32'h0340_0000};

  logic           clk = 1'b0;
  logic           rstn;
  logic           flush;
  logic [1:0]     in_valid;
  logic [191:0]   in_data;
  logic           in_ready;
  logic [1:0]     out_valid;
  logic [191:0]   out_data;
  logic [1:0]     pop_cnt;
  logic [3:0]     count;
  logic           full;

  int             n_chk = 0;
  int             n_err = 0;
  logic [31:0]    sb[$];
  logic [31:0]    p;

  fetch_queue #(
    .DEPTH  (DEPTH),
    .PUSH_W (PUSH_W),
    .POP_W  (POP_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pop_cnt   (pop_cnt),
    .count     (count),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] mk(input logic [31:0] pc);
    return {pc + 32'd4, pc, 16'hA500, pc[15:0]};
  endfunction

  function automatic logic [31:0] pc_of(input int lane);
    return out_data[lane*EW+32 +: 32];
  endfunction

  function automatic logic [95:0] lane_of(input int lane);
    return out_data[lane*EW +: EW];
  endfunction

  // Drive one cycle of stimulus, update the expected pc queue, and return 1 ns after the edge.
  task automatic cyc(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                     input int pop, input logic fl);
    int  old;
    bit  rdy;
    in_valid = v;
    in_data  = {mk(p1), mk(p0)};
    pop_cnt  = 2'(pop);
    flush    = fl;
    if (fl) begin
      sb.delete();
    end else begin
      old = sb.size();
      rdy = (DEPTH - old) >= PUSH_W;
      for (int k = 0; k < pop && sb.size() > 0; k++) void'(sb.pop_front());
      if (rdy) begin
        if (v[0]) sb.push_back(p0);
        if (v[1]) sb.push_back(p1);
      end
    end
    @(posedge clk);
    #1;
    in_valid = '0;
    pop_cnt  = '0;
    flush    = 1'b0;
  endtask

  initial begin
    rstn     = 1'b1;
    flush    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    pop_cnt  = '0;
    #1 rstn  = 1'b0;
    #11;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_full", full, 0);
    chk("rst_pad0", lane_of(0), PADV);
    chk("rst_pad1", lane_of(1), PADV);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;

    // Two-lane push
    cyc(2'b11, 32'h1c00_0000, 32'h1c00_0004, 0, 1'b0);
    chk("t1_count", count, 2);
    chk("t1_out_valid", out_valid, 2'b11);
    chk("t1_lane0_pc", pc_of(0), 32'h1c00_0000);
    chk("t1_lane1_pc", pc_of(1), 32'h1c00_0004);
    chk("t1_lane0_pcnext", out_data[64 +: 32], 32'h1c00_0004);

    // Lane 0 killed: only lane 1 is stored
    cyc(2'b10, 32'h1c00_0010, 32'h1c00_0014, 0, 1'b0);
    chk("t2_count", count, 3);
    chk("t2_lane0_pc", pc_of(0), 32'h1c00_0000);
    cyc(2'b00, 32'h0, 32'h0, 2, 1'b0);
    chk("t2_pop_count", count, 1);
    chk("t2_pop_out_valid", out_valid, 2'b01);
    chk("t2_compacted_pc", pc_of(0), 32'h1c00_0014);
    chk("t2_lane1_pad", lane_of(1), PADV);

    // Fill to 7, then a push is dropped while 2 are popped
    cyc(2'b11, 32'h1c00_0100, 32'h1c00_0104, 0, 1'b0);
    cyc(2'b11, 32'h1c00_0108, 32'h1c00_010c, 0, 1'b0);
    cyc(2'b11, 32'h1c00_0110, 32'h1c00_0114, 0, 1'b0);
    chk("t3_count7", count, 7);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_full", full, 1);
    cyc(2'b11, 32'h1c00_0180, 32'h1c00_0184, 2, 1'b0);
    chk("t3_drop_count", count, 5);
    chk("t3_drop_lane0", pc_of(0), 32'h1c00_0104);
    chk("t3_in_ready_again", in_ready, 1);
    cyc(2'b00, 32'h0, 32'h0, 2, 1'b0);
    chk("t3_head6_count", count, 3);
    chk("t3_head6_lane0", pc_of(0), 32'h1c00_010c);
    chk("t3_head6_lane1", pc_of(1), 32'h1c00_0110);

    // Steady push 2 / pop 2 across the wrap point
    p = 32'h1c00_0118;
    for (int n = 0; n < 20; n++) begin
      cyc(2'b11, p, p + 32'd4, 2, 1'b0);
      p = p + 32'd8;
      chk("t4_count", count, 3);
      chk("t4_out_valid", out_valid, 2'b11);
      chk("t4_lane0_pc", pc_of(0), sb[0]);
      chk("t4_lane1_pc", pc_of(1), sb[1]);
    end
    // After 20 cycles the oldest entry is the last of the dropped-free stream
    chk("t4_final_lane0", pc_of(0), 32'h1c00_01ac);

    // Flush beats simultaneous push and pop
    cyc(2'b01, p, 32'h0, 0, 1'b0);
    chk("t5_count4", count, 4);
    cyc(2'b11, 32'h1c00_0400, 32'h1c00_0404, 1, 1'b1);
    chk("t5_count", count, 0);
    chk("t5_out_valid", out_valid, 2'b00);
    chk("t5_pad0", lane_of(0), PADV);
    chk("t5_pad1", lane_of(1), PADV);
    chk("t5_in_ready", in_ready, 1);

    // Asynchronous reset mid-cycle
    cyc(2'b11, 32'h1c00_0200, 32'h1c00_0204, 0, 1'b0);
    cyc(2'b10, 32'h1c00_0208, 32'h1c00_020c, 0, 1'b0);
    chk("t6_count3", count, 3);
    #2 rstn = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_out_valid", out_valid, 2'b00);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_pad0", lane_of(0), PADV);
    #1 rstn = 1'b1;
    cyc(2'b11, 32'h1c00_0300, 32'h1c00_0304, 0, 1'b0);
    chk("t6_after_count", count, 2);
    chk("t6_after_lane0", pc_of(0), 32'h1c00_0300);
    chk("t6_after_lane1", pc_of(1), 32'h1c00_0304);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
